// File: rtl/decode_pkg.sv
// Shared types for the instruction decode stage: opcode encoding, class codes,
// the fixed-width part of a decoded instruction and the squash FSM states.
package decode_pkg;

    typedef enum logic [4:0] {
        OP_MOVF   = 5'd0,
        OP_MOVWF  = 5'd1,
        OP_ADDWF  = 5'd2,
        OP_SUBWF  = 5'd3,
        OP_ANDWF  = 5'd4,
        OP_INCF   = 5'd5,
        OP_DECF   = 5'd6,
        OP_XORWF  = 5'd7,
        OP_NOP    = 5'd8,
        OP_CLRF   = 5'd9,
        OP_IORWF  = 5'd10,
        OP_SWAPF  = 5'd11,
        OP_COMF   = 5'd12,
        OP_DECFSZ = 5'd13,
        OP_INCFSZ = 5'd14,
        OP_RLF    = 5'd15,
        OP_RRF    = 5'd16,
        OP_BCF    = 5'd17,
        OP_BSF    = 5'd18,
        OP_BTFSC  = 5'd19,
        OP_BTFSS  = 5'd20,
        OP_MOVLW  = 5'd21,
        OP_ADDLW  = 5'd22,
        OP_ANDLW  = 5'd23,
        OP_IORLW  = 5'd24,
        OP_XORLW  = 5'd25,
        OP_SUBLW  = 5'd26,
        OP_RETLW  = 5'd27,
        OP_GOTO   = 5'd28,
        OP_CALL   = 5'd29
    } op_e;

    localparam logic [1:0] CLS_BYTE = 2'b00;
    localparam logic [1:0] CLS_BIT  = 2'b01;
    localparam logic [1:0] CLS_CTRL = 2'b10;
    localparam logic [1:0] CLS_LIT  = 2'b11;

    // f, lit and target scale with INST_W, so they travel beside this struct
    typedef struct packed {
        op_e        op;
        logic       d;
        logic [2:0] bit_idx;
        logic       illegal;
    } dec_t;

    localparam dec_t DEC_RESET = '{op: OP_NOP, d: 1'b0, bit_idx: 3'd0, illegal: 1'b0};

    typedef enum logic {
        ST_RUN,
        ST_SQUASH
    } state_e;

    function automatic logic is_branch(input op_e op);
        return (op == OP_GOTO) || (op == OP_CALL) || (op == OP_RETLW);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake bundle around the decode stage: instruction stream in,
// decoded-field stream out. The stage uses slave, its neighbours master.
interface decode_stage_if #(
    parameter int unsigned INST_W = 8,
    parameter int unsigned OP_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_op;
    logic              out_d;
    logic [INST_W-8:0] out_f;
    logic [2:0]        out_bit;
    logic [INST_W-7:0] out_lit;
    logic [INST_W-4:0] out_target;
    logic              out_illegal;

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_op, out_d, out_f, out_bit,
               out_lit, out_target, out_illegal
    );

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_op, out_d, out_f, out_bit,
               out_lit, out_target, out_illegal
    );
endinterface

// File: rtl/decode_comb.sv
// Pure combinational field extractor and opcode decoder for all four
// instruction classes; fields not used by the class are driven to zero.
module decode_comb
    import decode_pkg::*;
#(
    parameter int unsigned INST_W = 8
) (
    input  logic [INST_W-1:0] i_inst,
    output dec_t              o_dec,
    output logic [INST_W-8:0] o_f,
    output logic [INST_W-7:0] o_lit,
    output logic [INST_W-4:0] o_target
);
    localparam int unsigned F_W = INST_W - 7;

    logic [1:0]        w_cls;
    logic [3:0]        w_code4;
    logic [1:0]        w_sub2;
    logic [2:0]        w_bit3;
    logic              w_d;
    logic              w_sel;
    logic [F_W-1:0]    w_f;
    logic [INST_W-7:0] w_lit;
    logic [INST_W-4:0] w_tgt;

    assign w_cls   = i_inst[INST_W-1 -: 2];
    assign w_code4 = i_inst[INST_W-3 -: 4];
    assign w_sub2  = i_inst[INST_W-3 -: 2];
    assign w_bit3  = i_inst[INST_W-5 -: 3];
    assign w_d     = i_inst[INST_W-7];
    assign w_sel   = i_inst[INST_W-3];
    assign w_f     = i_inst[F_W-1:0];
    assign w_lit   = i_inst[INST_W-7:0];
    assign w_tgt   = i_inst[INST_W-4:0];

    always_comb begin
        o_dec    = DEC_RESET;
        o_f      = '0;
        o_lit    = '0;
        o_target = '0;
        case (w_cls)
            CLS_BYTE: begin
                o_dec.d = w_d;
                o_f     = w_f;
                case (w_code4)
                    4'h0: o_dec.op = w_d ? OP_MOVWF : OP_NOP;
                    4'h1: o_dec.op = OP_CLRF;
                    4'h2: o_dec.op = OP_SUBWF;
                    4'h3: o_dec.op = OP_DECF;
                    4'h4: o_dec.op = OP_IORWF;
                    4'h5: o_dec.op = OP_ANDWF;
                    4'h6: o_dec.op = OP_XORWF;
                    4'h7: o_dec.op = OP_ADDWF;
                    4'h8: o_dec.op = OP_MOVF;
                    4'h9: o_dec.op = OP_COMF;
                    4'hA: o_dec.op = OP_INCF;
                    4'hB: o_dec.op = OP_DECFSZ;
                    4'hC: o_dec.op = OP_RRF;
                    4'hD: o_dec.op = OP_RLF;
                    4'hE: o_dec.op = OP_SWAPF;
                    default: o_dec.op = OP_INCFSZ;
                endcase
            end
            CLS_BIT: begin
                o_dec.bit_idx = w_bit3;
                o_f           = w_f;
                case (w_sub2)
                    2'b00:   o_dec.op = OP_BCF;
                    2'b01:   o_dec.op = OP_BSF;
                    2'b10:   o_dec.op = OP_BTFSC;
                    default: o_dec.op = OP_BTFSS;
                endcase
            end
            CLS_CTRL: begin
                o_dec.op = w_sel ? OP_GOTO : OP_CALL;
                o_target = w_tgt;
            end
            default: begin
                o_lit = w_lit;
                case (w_code4)
                    4'h0: o_dec.op = OP_MOVLW;
                    4'h1: o_dec.op = OP_RETLW;
                    4'h2: o_dec.op = OP_ADDLW;
                    4'h3: o_dec.op = OP_SUBLW;
                    4'h4: o_dec.op = OP_ANDLW;
                    4'h5: o_dec.op = OP_IORLW;
                    4'h6: o_dec.op = OP_XORLW;
                    default: begin
                        o_dec.op      = OP_NOP;
                        o_dec.illegal = 1'b1;
                        o_lit         = '0;
                    end
                endcase
            end
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage: one-deep output register plus a squash
// FSM that discards wrong-path instructions after branches and taken skips.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned INST_W    = 8,
    parameter int unsigned OP_W      = 5,
    parameter int unsigned BR_SQUASH = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           skip_i,
    decode_stage_if.slave  bus
);
    localparam logic [2:0] SQ_LOAD = 3'(BR_SQUASH);

    dec_t              w_dec;
    logic [INST_W-8:0] w_f;
    logic [INST_W-7:0] w_lit;
    logic [INST_W-4:0] w_target;

    logic   w_in_ready;
    logic   w_accept;
    logic   w_load;
    logic   w_branch;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic [2:0] w_cnt_base;
    logic [2:0] w_cnt_sum;

    logic              r_valid;
    dec_t              r_dec;
    logic [INST_W-8:0] r_f;
    logic [INST_W-7:0] r_lit;
    logic [INST_W-4:0] r_target;

    decode_comb #(.INST_W(INST_W)) u_decode_comb (
        .i_inst   (bus.in_inst),
        .o_dec    (w_dec),
        .o_f      (w_f),
        .o_lit    (w_lit),
        .o_target (w_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Discard and skip fold into one signed step so coincident events cancel
    always_comb begin
        w_cnt_base = '0;
        case (r_state)
            ST_RUN:  w_cnt_base = (w_accept && w_branch) ? SQ_LOAD : 3'd0;
            default: w_cnt_base = {1'b0, r_cnt} - {2'b00, w_accept};
        endcase
        w_cnt_sum   = w_cnt_base + {2'b00, skip_i};
        w_cnt_nxt   = (w_cnt_sum > 3'd3) ? 2'd3 : w_cnt_sum[1:0];
        w_state_nxt = (w_cnt_nxt != 2'd0) ? ST_SQUASH : ST_RUN;
    end

    always_comb begin
        w_in_ready = !r_valid || bus.out_ready;
        w_accept   = bus.in_valid && w_in_ready;
        w_load     = w_accept && (r_state == ST_RUN);
        w_branch   = is_branch(w_dec.op);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_dec    <= DEC_RESET;
            r_f      <= '0;
            r_lit    <= '0;
            r_target <= '0;
        end else if (w_in_ready) begin
            r_valid <= w_load;
            if (w_load) begin
                r_dec    <= w_dec;
                r_f      <= w_f;
                r_lit    <= w_lit;
                r_target <= w_target;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_valid;
    assign bus.out_op      = OP_W'(r_dec.op);
    assign bus.out_d       = r_dec.d;
    assign bus.out_f       = r_f;
    assign bus.out_bit     = r_dec.bit_idx;
    assign bus.out_lit     = r_lit;
    assign bus.out_target  = r_target;
    assign bus.out_illegal = r_dec.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (INST_W=8, BR_SQUASH=1): table of single
// decodes plus hand-written squash, stall, saturation and reset sequences.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    logic skip_i;

    always #5 clk = ~clk;

    decode_stage_if #(.INST_W(8), .OP_W(5)) bus ();

    decode_stage #(.INST_W(8), .OP_W(5), .BR_SQUASH(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .skip_i (skip_i),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] inst;
        logic [4:0] op;
        logic       d;
        logic       f;
        logic [2:0] b;
        logic [1:0] lit;
        logic       ill;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] pk(input logic v, input logic [4:0] op, input logic d,
                                       input logic f, input logic [2:0] b, input logic [1:0] lit,
                                       input logic [4:0] tgt, input logic ill);
        return {13'd0, v, op, d, f, b, lit, tgt, ill};
    endfunction

    function automatic logic [31:0] obs();
        return pk(bus.out_valid, bus.out_op, bus.out_d, bus.out_f, bus.out_bit,
                  bus.out_lit, bus.out_target, bus.out_illegal);
    endfunction

    task automatic cyc(input logic v, input logic [7:0] inst, input logic sk);
        bus.in_valid = v;
        bus.in_inst  = inst;
        skip_i       = sk;
        @(posedge clk);
        #1;
        skip_i = 1'b0;
    endtask

    task automatic chk_drop(input string name);
        chk(name, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{8'h1E, 5'd2,  1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[1]  = '{8'h00, 5'd8,  1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[2]  = '{8'h02, 5'd1,  1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[3]  = '{8'h0C, 5'd6,  1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[4]  = '{8'h05, 5'd9,  1'b0, 1'b1, 3'd0, 2'd0, 1'b0};
        vecs[5]  = '{8'h23, 5'd0,  1'b1, 1'b1, 3'd0, 2'd0, 1'b0};
        vecs[6]  = '{8'h3F, 5'd14, 1'b1, 1'b1, 3'd0, 2'd0, 1'b0};
        vecs[7]  = '{8'h32, 5'd16, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[8]  = '{8'h5A, 5'd18, 1'b0, 1'b0, 3'd5, 2'd0, 1'b0};
        vecs[9]  = '{8'h4F, 5'd17, 1'b0, 1'b1, 3'd7, 2'd0, 1'b0};
        vecs[10] = '{8'h62, 5'd19, 1'b0, 1'b0, 3'd1, 2'd0, 1'b0};
        vecs[11] = '{8'h7D, 5'd20, 1'b0, 1'b1, 3'd6, 2'd0, 1'b0};
        vecs[12] = '{8'hC3, 5'd21, 1'b0, 1'b0, 3'd0, 2'd3, 1'b0};
        vecs[13] = '{8'hCA, 5'd22, 1'b0, 1'b0, 3'd0, 2'd2, 1'b0};
        vecs[14] = '{8'hD9, 5'd25, 1'b0, 1'b0, 3'd0, 2'd1, 1'b0};
        vecs[15] = '{8'hDC, 5'd8,  1'b0, 1'b0, 3'd0, 2'd0, 1'b1};
        vecs[16] = '{8'hFF, 5'd8,  1'b0, 1'b0, 3'd0, 2'd0, 1'b1};
        vecs[17] = '{8'h1B, 5'd7,  1'b1, 1'b1, 3'd0, 2'd0, 1'b0};
        vecs[18] = '{8'h2E, 5'd13, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[19] = '{8'h12, 5'd10, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};

        rst           = 1'b1;
        skip_i        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", obs(), pk(1'b0, 5'd8, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0));
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;

        // back-to-back decode table
        for (int i = 0; i < NV; i++) begin
            cyc(1'b1, vecs[i].inst, 1'b0);
            chk($sformatf("vec%0d_%02h", i, vecs[i].inst), obs(),
                pk(1'b1, vecs[i].op, vecs[i].d, vecs[i].f, vecs[i].b, vecs[i].lit, 5'd0, vecs[i].ill));
        end
        cyc(1'b0, 8'h00, 1'b0);
        chk_drop("idle_drain");

        // GOTO squashes exactly one follower
        cyc(1'b1, 8'hA5, 1'b0);
        chk("goto", obs(), pk(1'b1, 5'd28, 1'b0, 1'b0, 3'd0, 2'd0, 5'd5, 1'b0));
        cyc(1'b1, 8'h1E, 1'b0);
        chk_drop("goto_drop");
        cyc(1'b1, 8'h0C, 1'b0);
        chk("goto_after", obs(), pk(1'b1, 5'd6, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0));

        // backpressure stall
        cyc(1'b1, 8'h5A, 1'b0);
        chk("stall_load", obs(), pk(1'b1, 5'd18, 1'b0, 1'b0, 3'd5, 2'd0, 5'd0, 1'b0));
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 8'h1E, 1'b0);
            chk($sformatf("stall_hold%0d", k), obs(), pk(1'b1, 5'd18, 1'b0, 1'b0, 3'd5, 2'd0, 5'd0, 1'b0));
            chk($sformatf("stall_in_ready%0d", k), {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        cyc(1'b1, 8'h1E, 1'b0);
        chk("stall_release", obs(), pk(1'b1, 5'd2, 1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0));

        // CALL with coincident skip drops two
        cyc(1'b1, 8'h80, 1'b1);
        chk("call_skip", obs(), pk(1'b1, 5'd29, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0));
        cyc(1'b1, 8'h1E, 1'b0);
        chk_drop("call_skip_drop0");
        cyc(1'b1, 8'h02, 1'b0);
        chk_drop("call_skip_drop1");
        cyc(1'b1, 8'h0C, 1'b0);
        chk("call_skip_after", obs(), pk(1'b1, 5'd6, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0));

        // counter saturates at 3
        cyc(1'b1, 8'h80, 1'b1);
        chk("sat_call", obs(), pk(1'b1, 5'd29, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0));
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        chk_drop("sat_idle");
        cyc(1'b1, 8'h1E, 1'b0);
        chk_drop("sat_drop0");
        cyc(1'b1, 8'h02, 1'b0);
        chk_drop("sat_drop1");
        cyc(1'b1, 8'h0C, 1'b0);
        chk_drop("sat_drop2");
        cyc(1'b1, 8'h05, 1'b0);
        chk("sat_after", obs(), pk(1'b1, 5'd9, 1'b0, 1'b1, 3'd0, 2'd0, 5'd0, 1'b0));

        // discard coinciding with skip keeps the count
        cyc(1'b1, 8'hA5, 1'b0);
        cyc(1'b1, 8'h1E, 1'b1);
        chk_drop("net_drop0");
        cyc(1'b1, 8'h02, 1'b0);
        chk_drop("net_drop1");
        cyc(1'b1, 8'h0C, 1'b0);
        chk("net_after", obs(), pk(1'b1, 5'd6, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0));

        // RETLW also squashes
        cyc(1'b1, 8'hC7, 1'b0);
        chk("retlw", obs(), pk(1'b1, 5'd27, 1'b0, 1'b0, 3'd0, 2'd3, 5'd0, 1'b0));
        cyc(1'b1, 8'h1E, 1'b0);
        chk_drop("retlw_drop");
        cyc(1'b1, 8'h02, 1'b0);
        chk("retlw_after", obs(), pk(1'b1, 5'd1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0));

        // asynchronous reset while squashing with a valid output
        cyc(1'b1, 8'hA5, 1'b0);
        chk("mid_goto", obs(), pk(1'b1, 5'd28, 1'b0, 1'b0, 3'd0, 2'd0, 5'd5, 1'b0));
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_reset_out", obs(), pk(1'b0, 5'd8, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0));
        chk("mid_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        #2;
        rst = 1'b0;
        cyc(1'b1, 8'hC3, 1'b0);
        chk("post_reset_movlw", obs(), pk(1'b1, 5'd21, 1'b0, 1'b0, 3'd0, 2'd3, 5'd0, 1'b0));
        cyc(1'b1, 8'h1E, 1'b0);
        chk("post_reset_no_squash", obs(), pk(1'b1, 5'd2, 1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0));

        bus.in_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
